// File: rtl/adc_capture_scheduler.sv
// adc_capture_scheduler
// Paces ADC conversions from a programmable divider, picks the channel for
// each conversion (single channel or alternating ch0/ch1), watches the
// trigger channel for a level crossing and then streams a fixed number of
// samples into the capture memory write port.
//
// Ports:
//   s_clk_i, rst_i          clock, synchronous active-high reset
//   divider_i               sample period minus one (clocks)
//   dual_ch_i, trig_ch_i    channel mode / trigger channel (latched on arm)
//   trig_level_i            trigger threshold (unsigned)
//   trig_rising_i           1 = rising crossing, 0 = falling crossing
//   depth_i                 samples to capture, 0 = 2^ADDR_W (latched on arm)
//   arm_i, force_i          start acquisition / force trigger while armed
//   start_sample_o          one-cycle conversion request to adc_driver
//   channel_num_o           channel of the current conversion
//   data_ready_i, data_i    conversion result from adc_driver
//   wr_en_o, wr_addr_o,
//   wr_data_o               capture memory write port, data = {channel, sample}
//   armed_o, triggered_o,
//   done_o                  state flags
//   overrun_o               sticky: a sample tick was dropped while busy
module adc_capture_scheduler #(
  parameter int DIV_W  = 16,
  parameter int ADDR_W = 10,
  parameter int DATA_W = 10
) (
  input  logic              s_clk_i,
  input  logic              rst_i,
  input  logic [DIV_W-1:0]  divider_i,
  input  logic              dual_ch_i,
  input  logic              trig_ch_i,
  input  logic [DATA_W-1:0] trig_level_i,
  input  logic              trig_rising_i,
  input  logic [ADDR_W-1:0] depth_i,
  input  logic              arm_i,
  input  logic              force_i,
  output logic              start_sample_o,
  output logic              channel_num_o,
  input  logic              data_ready_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [DATA_W:0]   wr_data_o,
  output logic              armed_o,
  output logic              triggered_o,
  output logic              done_o,
  output logic              overrun_o
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  localparam logic [DIV_W-1:0]  DIV_ONE  = DIV_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  state_t              state_r, state_next_s;
  logic [DIV_W-1:0]    cnt_r, cnt_next_s;
  logic                busy_r, busy_next_s;
  logic                ch_r, ch_next_s;
  logic                dual_r, dual_next_s;
  logic                trig_ch_r, trig_ch_next_s;
  logic [ADDR_W-1:0]   depth_r, depth_next_s;
  logic [ADDR_W-1:0]   addr_r, addr_next_s;
  logic [DATA_W-1:0]   prev_r, prev_next_s;
  logic                prev_valid_r, prev_valid_next_s;
  logic                overrun_r, overrun_next_s;
  logic                start_r, start_next_s;
  logic                wr_en_r, wr_en_next_s;
  logic [ADDR_W-1:0]   wr_addr_r, wr_addr_next_s;
  logic [DATA_W:0]     wr_data_r, wr_data_next_s;
  logic                armed_r, triggered_r, done_r;

  logic run_s, run_next_s, tick_s, result_s;
  logic rise_hit_s, fall_hit_s, trig_hit_s, last_s;

  assign run_s      = (state_r == ST_ARMED) || (state_r == ST_CAPTURE);
  assign tick_s     = run_s && (cnt_r == divider_i);
  // A result only counts when a conversion is actually outstanding.
  assign result_s   = data_ready_i && busy_r;
  assign rise_hit_s = (prev_r < trig_level_i) && (trig_level_i <= data_i);
  assign fall_hit_s = (prev_r >= trig_level_i) && (trig_level_i > data_i);
  assign trig_hit_s = prev_valid_r && (ch_r == trig_ch_r) &&
                      (trig_rising_i ? rise_hit_s : fall_hit_s);
  // depth 0 makes depth-1 all ones, i.e. a full 2^ADDR_W capture.
  assign last_s     = (addr_r == (depth_r - ADDR_ONE));

  // Next-state and next-value logic for the FSM and its datapath
  always_comb begin
    state_next_s      = state_r;
    cnt_next_s        = cnt_r;
    busy_next_s       = busy_r;
    ch_next_s         = ch_r;
    dual_next_s       = dual_r;
    trig_ch_next_s    = trig_ch_r;
    depth_next_s      = depth_r;
    addr_next_s       = addr_r;
    prev_next_s       = prev_r;
    prev_valid_next_s = prev_valid_r;
    overrun_next_s    = overrun_r;
    wr_en_next_s      = 1'b0;
    wr_addr_next_s    = wr_addr_r;
    wr_data_next_s    = wr_data_r;

    if (arm_i) begin
      state_next_s      = ST_ARMED;
      cnt_next_s        = '0;
      busy_next_s       = 1'b0;
      overrun_next_s    = 1'b0;
      addr_next_s       = '0;
      wr_addr_next_s    = '0;
      prev_valid_next_s = 1'b0;
      dual_next_s       = dual_ch_i;
      trig_ch_next_s    = trig_ch_i;
      depth_next_s      = depth_i;
      ch_next_s         = dual_ch_i ? 1'b0 : trig_ch_i;
    end else begin
      if (!run_s) begin
        cnt_next_s = cnt_r;
      end else if (tick_s) begin
        cnt_next_s = '0;
      end else begin
        cnt_next_s = cnt_r + DIV_ONE;
      end

      if (tick_s && busy_r) begin
        overrun_next_s = 1'b1;
      end else begin
        overrun_next_s = overrun_r;
      end

      // start_r marks the cycle the request leaves, so busy follows it.
      if (start_r) begin
        busy_next_s = 1'b1;
      end else if (result_s) begin
        busy_next_s = 1'b0;
      end else begin
        busy_next_s = busy_r;
      end

      if (result_s && dual_r) begin
        ch_next_s = ~ch_r;
      end else begin
        ch_next_s = ch_r;
      end

      case (state_r)
        ST_IDLE: begin
          state_next_s = ST_IDLE;
        end
        ST_ARMED: begin
          if (result_s && trig_hit_s) begin
            wr_en_next_s   = 1'b1;
            wr_addr_next_s = addr_r;
            wr_data_next_s = {ch_r, data_i};
            addr_next_s    = addr_r + ADDR_ONE;
            state_next_s   = last_s ? ST_DONE : ST_CAPTURE;
          end else if (force_i) begin
            state_next_s = ST_CAPTURE;
          end else if (result_s && (ch_r == trig_ch_r)) begin
            prev_next_s       = data_i;
            prev_valid_next_s = 1'b1;
          end else begin
            state_next_s = ST_ARMED;
          end
        end
        ST_CAPTURE: begin
          if (result_s) begin
            wr_en_next_s   = 1'b1;
            wr_addr_next_s = addr_r;
            wr_data_next_s = {ch_r, data_i};
            addr_next_s    = addr_r + ADDR_ONE;
            state_next_s   = last_s ? ST_DONE : ST_CAPTURE;
          end else begin
            state_next_s = ST_CAPTURE;
          end
        end
        ST_DONE: begin
          state_next_s = ST_DONE;
        end
        default: begin
          state_next_s = ST_IDLE;
        end
      endcase
    end

    // The start request is registered, so it is decided one cycle ahead
    // from the values the counter, busy flag and state are about to take.
    run_next_s   = (state_next_s == ST_ARMED) || (state_next_s == ST_CAPTURE);
    start_next_s = run_next_s && (cnt_next_s == divider_i) && !busy_next_s;
  end

  // FSM state register
  always_ff @(posedge s_clk_i) begin
    if (rst_i) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Datapath, pacing, capture-port and flag registers
  always_ff @(posedge s_clk_i) begin
    if (rst_i) begin
      cnt_r        <= '0;
      busy_r       <= 1'b0;
      ch_r         <= 1'b0;
      dual_r       <= 1'b0;
      trig_ch_r    <= 1'b0;
      depth_r      <= '0;
      addr_r       <= '0;
      prev_r       <= '0;
      prev_valid_r <= 1'b0;
      overrun_r    <= 1'b0;
      start_r      <= 1'b0;
      wr_en_r      <= 1'b0;
      wr_addr_r    <= '0;
      wr_data_r    <= '0;
      armed_r      <= 1'b0;
      triggered_r  <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      cnt_r        <= cnt_next_s;
      busy_r       <= busy_next_s;
      ch_r         <= ch_next_s;
      dual_r       <= dual_next_s;
      trig_ch_r    <= trig_ch_next_s;
      depth_r      <= depth_next_s;
      addr_r       <= addr_next_s;
      prev_r       <= prev_next_s;
      prev_valid_r <= prev_valid_next_s;
      overrun_r    <= overrun_next_s;
      start_r      <= start_next_s;
      wr_en_r      <= wr_en_next_s;
      wr_addr_r    <= wr_addr_next_s;
      wr_data_r    <= wr_data_next_s;
      armed_r      <= (state_next_s == ST_ARMED);
      triggered_r  <= (state_next_s == ST_CAPTURE);
      done_r       <= (state_next_s == ST_DONE);
    end
  end

  assign start_sample_o = start_r;
  assign channel_num_o  = ch_r;
  assign wr_en_o        = wr_en_r;
  assign wr_addr_o      = wr_addr_r;
  assign wr_data_o      = wr_data_r;
  assign armed_o        = armed_r;
  assign triggered_o    = triggered_r;
  assign done_o         = done_r;
  assign overrun_o      = overrun_r;

endmodule

// File: tb/tb_adc_capture_scheduler.sv
// Testbench for adc_capture_scheduler: behavioural ADC responder plus a
// write-port scoreboard; each scenario task drives stimulus and checks flags.
module tb_adc_capture_scheduler;
  localparam int DIV_W  = 16;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 10;
  localparam logic [DATA_W-1:0] FLAT = 10'd50;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              ch;
    logic [DATA_W-1:0] data;
  } wr_t;

  logic              s_clk_i;
  logic              rst_i;
  logic [DIV_W-1:0]  divider_i;
  logic              dual_ch_i;
  logic              trig_ch_i;
  logic [DATA_W-1:0] trig_level_i;
  logic              trig_rising_i;
  logic [ADDR_W-1:0] depth_i;
  logic              arm_i;
  logic              force_i;
  logic              start_sample_o;
  logic              channel_num_o;
  logic              data_ready_i;
  logic [DATA_W-1:0] data_i;
  logic              wr_en_o;
  logic [ADDR_W-1:0] wr_addr_o;
  logic [DATA_W:0]   wr_data_o;
  logic              armed_o;
  logic              triggered_o;
  logic              done_o;
  logic              overrun_o;

  int checks   = 0;
  int failures = 0;

  wr_t               exp_q[$];
  logic [DATA_W-1:0] ch0_q[$];
  logic [DATA_W-1:0] ch1_q[$];
  int                adc_lat   = 3;
  int                adc_cd    = 0;
  logic              adc_ch    = 1'b0;
  int                start_cnt = 0;

  adc_capture_scheduler #(.DIV_W(DIV_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .s_clk_i(s_clk_i), .rst_i(rst_i), .divider_i(divider_i),
    .dual_ch_i(dual_ch_i), .trig_ch_i(trig_ch_i), .trig_level_i(trig_level_i),
    .trig_rising_i(trig_rising_i), .depth_i(depth_i), .arm_i(arm_i),
    .force_i(force_i), .start_sample_o(start_sample_o),
    .channel_num_o(channel_num_o), .data_ready_i(data_ready_i),
    .data_i(data_i), .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o),
    .wr_data_o(wr_data_o), .armed_o(armed_o), .triggered_o(triggered_o),
    .done_o(done_o), .overrun_o(overrun_o)
  );

  initial s_clk_i = 1'b0;
  always #5 s_clk_i = ~s_clk_i;

  // ADC responder: a start seen at a falling edge returns a result adc_lat cycles later
  initial begin : adc_model
    data_ready_i = 1'b0;
    data_i       = '0;
    forever begin
      @(negedge s_clk_i);
      data_ready_i = 1'b0;
      if (adc_cd > 0) begin
        adc_cd = adc_cd - 1;
        if (adc_cd == 0) begin
          checks++;
          if (channel_num_o !== adc_ch) begin
            failures++;
            $display("FAIL chan_hold: channel_num_o=%0b at ready, required %0b", channel_num_o, adc_ch);
          end
          data_ready_i = 1'b1;
          if (adc_ch == 1'b0) begin
            if (ch0_q.size() > 0) data_i = ch0_q.pop_front();
            else data_i = FLAT;
          end else begin
            if (ch1_q.size() > 0) data_i = ch1_q.pop_front();
            else data_i = FLAT;
          end
        end
      end
      if (start_sample_o === 1'b1) begin
        start_cnt++;
        adc_cd = adc_lat;
        adc_ch = channel_num_o;
      end
    end
  end

  // Scoreboard: every write must match the oldest expected entry
  initial begin : wr_monitor
    wr_t exp_w;
    forever begin
      @(negedge s_clk_i);
      if (wr_en_o === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_write: addr=%0d data=%h, required no write", wr_addr_o, wr_data_o);
        end else begin
          exp_w = exp_q.pop_front();
          if ({wr_addr_o, wr_data_o} !== exp_w) begin
            failures++;
            $display("FAIL write: addr=%0d ch=%0b data=%0d, required addr=%0d ch=%0b data=%0d",
                     wr_addr_o, wr_data_o[DATA_W], wr_data_o[DATA_W-1:0],
                     exp_w.addr, exp_w.ch, exp_w.data);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic tick_();
    @(posedge s_clk_i);
    #1;
  endtask

  task automatic push_exp(input int addr, input logic ch, input int data);
    exp_q.push_back(wr_t'{ADDR_W'(addr), ch, DATA_W'(data)});
  endtask

  task automatic do_reset();
    rst_i = 1'b1; arm_i = 1'b0; force_i = 1'b0;
    adc_cd = 0; ch0_q.delete(); ch1_q.delete(); exp_q.delete();
    repeat (2) tick_();
    rst_i = 1'b0;
  endtask

  task automatic arm_cfg(input int div, input logic dual, input logic tch,
                         input int lvl, input logic rising, input int depth);
    divider_i     = DIV_W'(div);
    dual_ch_i     = dual;
    trig_ch_i     = tch;
    trig_level_i  = DATA_W'(lvl);
    trig_rising_i = rising;
    depth_i       = ADDR_W'(depth);
    arm_i         = 1'b1;
    tick_();
    arm_i         = 1'b0;
  endtask

  task automatic wait_start(input int budget, output bit found);
    found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge s_clk_i);
      if (start_sample_o === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge s_clk_i);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d writes still outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Pulse force right after a start so the following result is the first capture
  task automatic force_capture(input int base, input int n);
    bit found;
    wait_start(40, found);
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL force_sync: no start_sample_o seen, required one");
    end
    tick_();
    force_i = 1'b1;
    for (int i = 0; i < n; i++) begin
      ch0_q.push_back(DATA_W'(base + i));
      push_exp(i, 1'b0, base + i);
    end
    tick_();
    force_i = 1'b0;
  endtask

  task automatic test_reset();
    logic [21:0] outs;
    int s0;
    do_reset();
    outs = {start_sample_o, channel_num_o, wr_en_o, wr_addr_o, wr_data_o,
            armed_o, triggered_o, done_o, overrun_o};
    checks++;
    if (outs !== 22'd0) begin
      failures++;
      $display("FAIL reset_outputs: got %h, required 0", outs);
    end
    s0 = start_cnt;
    repeat (20) @(negedge s_clk_i);
    checks++;
    if (start_cnt != s0) begin
      failures++;
      $display("FAIL idle_no_start: %0d starts in IDLE, required 0", start_cnt - s0);
    end
  endtask

  task automatic test_single_rising();
    int n;
    bit seen;
    logic trig_prev;
    do_reset();
    adc_lat = 3;
    ch1_q = '{10'd100, 10'd200, 10'd400, 10'd500};
    push_exp(0, 1'b1, 400);
    push_exp(1, 1'b1, 500);
    arm_cfg(9, 1'b0, 1'b1, 300, 1'b1, 2);
    checks++;
    if (armed_o !== 1'b1) begin
      failures++;
      $display("FAIL armed_flag: armed_o=%0b, required 1", armed_o);
    end
    checks++;
    if (channel_num_o !== 1'b1) begin
      failures++;
      $display("FAIL single_channel: channel_num_o=%0b, required 1", channel_num_o);
    end
    n = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge s_clk_i);
      if (start_sample_o === 1'b1) break;
      n++;
    end
    checks++;
    if (n != 10) begin
      failures++;
      $display("FAIL first_start_latency: %0d cycles, required 10", n);
    end
    seen = 1'b0;
    trig_prev = triggered_o;
    for (int i = 0; i < 200; i++) begin
      @(negedge s_clk_i);
      if (wr_en_o === 1'b1) begin
        seen = 1'b1;
        break;
      end
      trig_prev = triggered_o;
    end
    checks++;
    if (!seen || trig_prev !== 1'b0 || triggered_o !== 1'b1) begin
      failures++;
      $display("FAIL trig_with_write: seen=%0b before=%0b at_write=%0b, required 1/0/1",
               seen, trig_prev, triggered_o);
    end
    wait_drain(200);
    checks++;
    if ({armed_o, triggered_o, done_o} !== 3'b001) begin
      failures++;
      $display("FAIL single_done_flags: %b, required 001", {armed_o, triggered_o, done_o});
    end
  endtask

  task automatic test_dual_depth();
    int s0;
    do_reset();
    adc_lat = 3;
    ch0_q = '{10'd100, 10'd400, 10'd555};
    ch1_q = '{10'd11, 10'd22, 10'd33};
    push_exp(0, 1'b0, 400);
    push_exp(1, 1'b1, 22);
    push_exp(2, 1'b0, 555);
    push_exp(3, 1'b1, 33);
    arm_cfg(9, 1'b1, 1'b0, 300, 1'b1, 4);
    checks++;
    if (channel_num_o !== 1'b0) begin
      failures++;
      $display("FAIL dual_first_channel: channel_num_o=%0b, required 0", channel_num_o);
    end
    wait_drain(300);
    checks++;
    if (done_o !== 1'b1) begin
      failures++;
      $display("FAIL dual_done: done_o=%0b, required 1", done_o);
    end
    s0 = start_cnt;
    repeat (50) @(negedge s_clk_i);
    checks++;
    if (start_cnt != s0) begin
      failures++;
      $display("FAIL done_no_start: %0d starts after DONE, required 0", start_cnt - s0);
    end
  endtask

  task automatic test_falling();
    do_reset();
    adc_lat = 3;
    ch0_q = '{10'd500, 10'd300, 10'd299, 10'd250};
    push_exp(0, 1'b0, 299);
    push_exp(1, 1'b0, 250);
    arm_cfg(9, 1'b0, 1'b0, 300, 1'b0, 2);
    wait_drain(300);
    checks++;
    if (done_o !== 1'b1) begin
      failures++;
      $display("FAIL falling_done: done_o=%0b, required 1", done_o);
    end
  endtask

  task automatic test_overrun();
    bit found;
    int extra;
    do_reset();
    adc_lat = 8;
    arm_cfg(2, 1'b0, 1'b0, 1023, 1'b1, 0);
    checks++;
    if (overrun_o !== 1'b0) begin
      failures++;
      $display("FAIL overrun_initial: overrun_o=%0b, required 0", overrun_o);
    end
    wait_start(20, found);
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL overrun_first_start: no start_sample_o pulse, required one");
    end
    extra = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge s_clk_i);
      if (start_sample_o === 1'b1) extra++;
    end
    checks++;
    if (extra != 0) begin
      failures++;
      $display("FAIL start_while_busy: %0d starts before ready, required 0", extra);
    end
    checks++;
    if (overrun_o !== 1'b1) begin
      failures++;
      $display("FAIL overrun_set: overrun_o=%0b, required 1", overrun_o);
    end
    wait_start(5, found);
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL start_after_ready: no start_sample_o pulse, required one");
    end
    repeat (30) @(negedge s_clk_i);
    checks++;
    if (overrun_o !== 1'b1) begin
      failures++;
      $display("FAIL overrun_sticky: overrun_o=%0b, required 1", overrun_o);
    end
    arm_cfg(2, 1'b0, 1'b0, 1023, 1'b1, 0);
    checks++;
    if (overrun_o !== 1'b0) begin
      failures++;
      $display("FAIL overrun_cleared_by_arm: overrun_o=%0b, required 0", overrun_o);
    end
  endtask

  task automatic test_force_full_depth();
    do_reset();
    adc_lat = 3;
    arm_cfg(4, 1'b0, 1'b0, 1023, 1'b1, 0);
    repeat (12) @(negedge s_clk_i);
    checks++;
    if ({armed_o, triggered_o} !== 2'b10) begin
      failures++;
      $display("FAIL flat_stays_armed: armed/triggered=%b, required 10", {armed_o, triggered_o});
    end
    force_capture(100, 16);
    checks++;
    if (triggered_o !== 1'b1) begin
      failures++;
      $display("FAIL force_triggered: triggered_o=%0b, required 1", triggered_o);
    end
    wait_drain(300);
    checks++;
    if ({done_o, wr_addr_o} !== {1'b1, 4'd15}) begin
      failures++;
      $display("FAIL full_depth_done: done=%0b last_addr=%0d, required 1/15", done_o, wr_addr_o);
    end
    repeat (20) @(negedge s_clk_i);
  endtask

  task automatic test_reset_in_capture();
    bit seen;
    bit found;
    int s0;
    logic [21:0] outs;
    do_reset();
    adc_lat = 3;
    arm_cfg(4, 1'b0, 1'b0, 1023, 1'b1, 0);
    checks++;
    if (done_o !== 1'b0) begin
      failures++;
      $display("FAIL done_clear: done_o=%0b, required 0", done_o);
    end
    force_capture(200, 5);
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge s_clk_i);
      if (wr_en_o === 1'b1 && wr_addr_o == 4'd4) begin
        seen = 1'b1;
        break;
      end
    end
    wait_start(20, found);
    checks++;
    if (!seen || !found) begin
      failures++;
      $display("FAIL reach_addr5: write4=%0b next_start=%0b, required 1/1", seen, found);
    end
    tick_();
    rst_i = 1'b1;
    tick_();
    rst_i = 1'b0;
    outs = {start_sample_o, channel_num_o, wr_en_o, wr_addr_o, wr_data_o,
            armed_o, triggered_o, done_o, overrun_o};
    checks++;
    if (outs !== 22'd0) begin
      failures++;
      $display("FAIL reset_in_capture: outputs %h, required 0", outs);
    end
    s0 = start_cnt;
    repeat (12) @(negedge s_clk_i);
    checks++;
    if (start_cnt != s0 || triggered_o !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_idle: starts=%0d triggered=%0b, required 0/0",
               start_cnt - s0, triggered_o);
    end
  endtask

  task automatic test_rearm_in_capture();
    do_reset();
    adc_lat = 4;
    arm_cfg(2, 1'b0, 1'b0, 1023, 1'b1, 0);
    force_capture(300, 3);
    wait_drain(100);
    checks++;
    if ({triggered_o, overrun_o} !== 2'b11) begin
      failures++;
      $display("FAIL capture_overrun: triggered/overrun=%b, required 11", {triggered_o, overrun_o});
    end
    arm_cfg(2, 1'b0, 1'b0, 1023, 1'b1, 2);
    checks++;
    if ({armed_o, triggered_o, done_o, overrun_o, wr_addr_o} !== {4'b1000, 4'd0}) begin
      failures++;
      $display("FAIL rearm_state: a/t/d/o=%b addr=%0d, required 1000/0",
               {armed_o, triggered_o, done_o, overrun_o}, wr_addr_o);
    end
    repeat (20) @(negedge s_clk_i);
    force_capture(700, 2);
    wait_drain(100);
    checks++;
    if (done_o !== 1'b1) begin
      failures++;
      $display("FAIL rearm_done: done_o=%0b, required 1", done_o);
    end
  endtask

  initial begin : main
    rst_i = 1'b1; arm_i = 1'b0; force_i = 1'b0;
    divider_i = '0; dual_ch_i = 1'b0; trig_ch_i = 1'b0;
    trig_level_i = '0; trig_rising_i = 1'b1; depth_i = '0;
    test_reset();
    test_single_rising();
    test_dual_depth();
    test_falling();
    test_overrun();
    test_force_full_depth();
    test_reset_in_capture();
    test_rearm_in_capture();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
